prm_oblgc_sched: RTL

Sequencer for the PRM obstacle-lattice edge-check bank. Accepts a stream of 15-bit obstacle codes, presents each code to the combinational checker bank (one `prm_oblgc_chk*` instance per roadmap edge), and ORs the returned per-edge masks into one blocked-edge bitmap per scan. It sits between the obstacle-voxel source and the roadmap graph-search logic, and returns the bitmap through a valid/ready handshake.

---
 rtl/prm_oblgc_pkg.sv | 7 +
 rtl/prm_oblgc_sched_if.sv | 18 +
 rtl/prm_oblgc_vldpipe.sv | 13 +
 rtl/prm_oblgc_sched.sv | 80 ++++++++
 4 files changed

// File: rtl/prm_oblgc_pkg.sv
// prm_oblgc_pkg: shared types and constants for the obstacle-lattice edge-check sequencer
package prm_oblgc_pkg;
    localparam int OBS_W = 15;
    localparam int CHK_LAT_MAX = 4;
    typedef logic [OBS_W-1:0] obs_code_t;
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} sched_state_e;
endpackage

// File: rtl/prm_oblgc_sched_if.sv
// prm_oblgc_sched_if: control, obstacle stream, checker bank and result signals of the sequencer
interface prm_oblgc_sched_if #(
    parameter int NUM_EDGES = 512,
    parameter int CNT_W = 10
);
    logic start, abort, obs_valid, obs_ready, res_valid, res_ready, res_hit, busy;
    logic [CNT_W-1:0] obs_cnt, res_obs;
    prm_oblgc_pkg::obs_code_t obs_data, chk_vec;
    logic [NUM_EDGES-1:0] chk_mask, res_mask;
    modport master(
        output start, obs_cnt, abort, obs_valid, obs_data, chk_mask, res_ready,
        input obs_ready, chk_vec, res_valid, res_mask, res_hit, res_obs, busy
    );
    modport slave(
        input start, obs_cnt, abort, obs_valid, obs_data, chk_mask, res_ready,
        output obs_ready, chk_vec, res_valid, res_mask, res_hit, res_obs, busy
    );
endinterface

// File: rtl/prm_oblgc_vldpipe.sv
// prm_oblgc_vldpipe: valid shift register tracking codes in flight through the checker bank
module prm_oblgc_vldpipe #(
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             din,
    output logic [DEPTH-1:0] q
);
    always_ff @(posedge clk)
        q <= (!rst_n || clr) ? '0 : (q << 1) | DEPTH'(din);
endmodule

// File: rtl/prm_oblgc_sched.sv
// prm_oblgc_sched: feeds obstacle codes to the checker bank and ORs returned masks into one bitmap per scan
module prm_oblgc_sched
    import prm_oblgc_pkg::*;
#(
    parameter int NUM_EDGES = 512,
    parameter int CHK_LAT = 0,
    parameter int CNT_W = 10
) (
    input logic clk,
    input logic rst_n,
    prm_oblgc_sched_if.slave bus
);
    localparam logic [CHK_LAT:0] LAST = (CHK_LAT+1)'(1) << CHK_LAT;
    sched_state_e state;
    logic [CNT_W-1:0] remain;
    logic [NUM_EDGES-1:0] acc;
    logic [CHK_LAT:0] vq;
    logic hs, kill, last;
    assign hs = bus.obs_valid && bus.obs_ready;
    assign kill = bus.abort && (state == SCAN || state == DRAIN);
    // only the oldest entry left in flight means this edge folds in the final mask
    assign last = state == DRAIN && vq == LAST;
    assign bus.busy = state != IDLE;
    assign bus.res_mask = acc;
    assign bus.res_hit = |acc;
    prm_oblgc_vldpipe #(.DEPTH(CHK_LAT + 1)) u_vldpipe (
        .clk(clk),
        .rst_n(rst_n),
        .clr(kill),
        .din(hs && !kill),
        .q(vq)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            remain <= '0;
            acc <= '0;
            bus.res_obs <= '0;
            bus.chk_vec <= '0;
            bus.obs_ready <= 1'b0;
            bus.res_valid <= 1'b0;
        end else begin
            if (hs && !kill) begin
                bus.chk_vec <= bus.obs_data;
                remain <= remain - 1'b1;
                bus.res_obs <= bus.res_obs + 1'b1;
            end
            if (vq[CHK_LAT] && !kill)
                acc <= acc | bus.chk_mask;
            if (kill) begin
                state <= IDLE;
                acc <= '0;
                bus.obs_ready <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (bus.start) begin
                        acc <= '0;
                        bus.res_obs <= '0;
                        remain <= bus.obs_cnt;
                        state <= bus.obs_cnt == '0 ? DONE : SCAN;
                        bus.obs_ready <= bus.obs_cnt != '0;
                        bus.res_valid <= bus.obs_cnt == '0;
                    end
                    SCAN: if (hs && remain == CNT_W'(1)) begin
                        state <= DRAIN;
                        bus.obs_ready <= 1'b0;
                    end
                    DRAIN: if (last) begin
                        state <= DONE;
                        bus.res_valid <= 1'b1;
                    end
                    DONE: if (bus.res_ready) begin
                        state <= IDLE;
                        bus.res_valid <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
